// File: rtl/leaderboard_scanner_pkg.sv
// Shared definitions for the leaderboard read-side scanner: widths, rank
// encoding, FSM states and the double-dabble step used by the converter.
package leaderboard_scanner_pkg;

    localparam int SCORE_W = 8;
    localparam int BCD_W   = 4;
    // Working register of the converter: three BCD digits above the binary.
    localparam int CONV_W  = 3 * BCD_W + SCORE_W;
    // One shift per binary bit.
    localparam int ITER_N  = SCORE_W;

    // Rank encoding: 0 = nothing shown, 1..3 = leaderboard places.
    localparam logic [1:0] RANK_NONE = 2'd0;
    localparam logic [1:0] RANK_1    = 2'd1;
    localparam logic [1:0] RANK_2    = 2'd2;
    localparam logic [1:0] RANK_3    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Corrects one BCD nibble so that the following left shift carries
    // properly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // One double-dabble iteration: fix up every BCD nibble, then shift left.
    function automatic logic [CONV_W-1:0] dabble_step(input logic [CONV_W-1:0] w);
        logic [CONV_W-1:0] a;
        a = w;
        a[SCORE_W + 2*BCD_W +: BCD_W] = add3_if_ge5(w[SCORE_W + 2*BCD_W +: BCD_W]);
        a[SCORE_W + BCD_W   +: BCD_W] = add3_if_ge5(w[SCORE_W + BCD_W   +: BCD_W]);
        a[SCORE_W           +: BCD_W] = add3_if_ge5(w[SCORE_W           +: BCD_W]);
        return {a[CONV_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/leaderboard_scanner_if.sv
// Bus between the leaderboard/prescaler side and the score display side.
//
// Signalling: start is level-sampled only while the scanner is idle (busy=0)
// and ignored otherwise; stop aborts any scan and wins over start and tick;
// tick is a one-cycle strobe. On the output side, valid=1 qualifies
// bcd_h/t/o as the stable score of the place given by rank; while valid=0
// the digits must not be consumed. dbg_state mirrors the FSM state.
interface leaderboard_scanner_if;
    import leaderboard_scanner_pkg::*;

    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [SCORE_W-1:0] score3;
    logic               start;
    logic               stop;
    logic               tick;
    logic [1:0]         rank;
    logic [BCD_W-1:0]   bcd_h;
    logic [BCD_W-1:0]   bcd_t;
    logic [BCD_W-1:0]   bcd_o;
    logic               valid;
    logic               busy;
    state_t             dbg_state;

    modport master (
        output score1, score2, score3, start, stop, tick,
        input  rank, bcd_h, bcd_t, bcd_o, valid, busy, dbg_state
    );

    modport slave (
        input  score1, score2, score3, start, stop, tick,
        output rank, bcd_h, bcd_t, bcd_o, valid, busy, dbg_state
    );

endinterface

// File: rtl/leaderboard_scanner_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// load restarts a conversion; done rises after the eighth iteration and
// stays high until the next load.
module bin2bcd_seq
    import leaderboard_scanner_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [SCORE_W-1:0] bin_i,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_h_o,
    output logic [BCD_W-1:0]   bcd_t_o,
    output logic [BCD_W-1:0]   bcd_o_o
);

    localparam logic [2:0] ITER_LAST = 3'(ITER_N - 1);

    logic [CONV_W-1:0] work_q, work_d;
    logic [2:0]        iter_q, iter_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    // Next-state: load seeds the working register, otherwise iterate while running.
    always_comb begin
        work_d = work_q;
        iter_d = iter_q;
        run_d  = run_q;
        done_d = done_q;
        if (load_i) begin
            work_d = {{(3*BCD_W){1'b0}}, bin_i};
            iter_d = 3'd0;
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            work_d = dabble_step(work_q);
            iter_d = iter_q + 3'd1;
            if (iter_q == ITER_LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Converter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            work_q <= work_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o  = done_q;
    assign bcd_h_o = work_q[SCORE_W + 2*BCD_W +: BCD_W];
    assign bcd_t_o = work_q[SCORE_W + BCD_W   +: BCD_W];
    assign bcd_o_o = work_q[SCORE_W           +: BCD_W];

endmodule

// File: rtl/leaderboard_scanner.sv
// Leaderboard scanner top: snapshots the three scores, converts each to BCD
// and holds each place on the outputs for DWELL prescaler ticks.
module leaderboard_scanner
    import leaderboard_scanner_pkg::*;
#(
    parameter int unsigned DWELL      = 4,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    leaderboard_scanner_if.slave bus
);

    // A rank is released on the tick that would bring the count to DWELL.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t             state_q, state_d;
    logic [1:0]         rank_q, rank_d;
    logic [BCD_W-1:0]   bcd_h_q, bcd_h_d;
    logic [BCD_W-1:0]   bcd_t_q, bcd_t_d;
    logic [BCD_W-1:0]   bcd_o_q, bcd_o_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [SCORE_W-1:0] snap1_q, snap1_d;
    logic [SCORE_W-1:0] snap2_q, snap2_d;
    logic [SCORE_W-1:0] snap3_q, snap3_d;
    logic [7:0]         dwell_q, dwell_d;

    logic               conv_load;
    logic [SCORE_W-1:0] conv_bin;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_h, conv_t, conv_o;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .load_i  (conv_load),
        .bin_i   (conv_bin),
        .done_o  (conv_done),
        .bcd_h_o (conv_h),
        .bcd_t_o (conv_t),
        .bcd_o_o (conv_o)
    );

    // Next-state and output logic of the scan FSM; stop overrides tick and start.
    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        bcd_h_d   = bcd_h_q;
        bcd_t_d   = bcd_t_q;
        bcd_o_d   = bcd_o_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        snap1_d   = snap1_q;
        snap2_d   = snap2_q;
        snap3_d   = snap3_q;
        dwell_d   = dwell_q;
        conv_load = 1'b0;
        conv_bin  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    snap1_d   = bus.score1;
                    snap2_d   = bus.score2;
                    snap3_d   = bus.score3;
                    rank_d    = RANK_1;
                    conv_load = 1'b1;
                    conv_bin  = bus.score1;
                    busy_d    = 1'b1;
                    state_d   = ST_CONV;
                end
            end

            ST_CONV: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    rank_d  = RANK_NONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (conv_done) begin
                    bcd_h_d = conv_h;
                    bcd_t_d = conv_t;
                    bcd_o_d = conv_o;
                    valid_d = 1'b1;
                    dwell_d = 8'd0;
                    state_d = ST_SHOW;
                end
            end

            ST_SHOW: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    rank_d  = RANK_NONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (bus.tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        // Dwell expired: this tick is consumed by the advance.
                        valid_d = 1'b0;
                        dwell_d = 8'd0;
                        if (rank_q != RANK_3) begin
                            rank_d    = rank_q + 2'd1;
                            conv_load = 1'b1;
                            conv_bin  = (rank_q == RANK_1) ? snap2_q : snap3_q;
                            state_d   = ST_CONV;
                        end else if (CONTINUOUS) begin
                            snap1_d   = bus.score1;
                            snap2_d   = bus.score2;
                            snap3_d   = bus.score3;
                            rank_d    = RANK_1;
                            conv_load = 1'b1;
                            conv_bin  = bus.score1;
                            state_d   = ST_CONV;
                        end else begin
                            // Last place done: digits keep their final value.
                            rank_d  = RANK_NONE;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                rank_d  = RANK_NONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything including the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rank_q  <= RANK_NONE;
            bcd_h_q <= '0;
            bcd_t_q <= '0;
            bcd_o_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            snap1_q <= '0;
            snap2_q <= '0;
            snap3_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            bcd_h_q <= bcd_h_d;
            bcd_t_q <= bcd_t_d;
            bcd_o_q <= bcd_o_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            snap3_q <= snap3_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.rank      = rank_q;
    assign bus.bcd_h     = bcd_h_q;
    assign bus.bcd_t     = bcd_t_q;
    assign bus.bcd_o     = bcd_o_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_leaderboard_scanner.sv
// Bench for leaderboard_scanner: one single-pass and one continuous instance
// share the stimulus; sel chooses which one is observed.
module tb_leaderboard_scanner;
    import leaderboard_scanner_pkg::*;

    localparam int DWELL = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] score1_v, score2_v, score3_v;
    logic       start_v, stop_v, tick_v;
    bit         sel;

    int checks   = 0;
    int failures = 0;

    leaderboard_scanner_if if0 ();
    leaderboard_scanner_if if1 ();

    assign if0.score1 = score1_v;
    assign if0.score2 = score2_v;
    assign if0.score3 = score3_v;
    assign if0.start  = start_v;
    assign if0.stop   = stop_v;
    assign if0.tick   = tick_v;
    assign if1.score1 = score1_v;
    assign if1.score2 = score2_v;
    assign if1.score3 = score3_v;
    assign if1.start  = start_v;
    assign if1.stop   = stop_v;
    assign if1.tick   = tick_v;

    leaderboard_scanner #(.DWELL(DWELL), .CONTINUOUS(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    leaderboard_scanner #(.DWELL(DWELL), .CONTINUOUS(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    logic [1:0] o_rank;
    logic [3:0] o_h, o_t, o_o;
    logic       o_valid, o_busy;
    state_t     o_state;
    assign o_rank  = sel ? if1.rank      : if0.rank;
    assign o_h     = sel ? if1.bcd_h     : if0.bcd_h;
    assign o_t     = sel ? if1.bcd_t     : if0.bcd_t;
    assign o_o     = sel ? if1.bcd_o     : if0.bcd_o;
    assign o_valid = sel ? if1.valid     : if0.valid;
    assign o_busy  = sel ? if1.busy      : if0.busy;
    assign o_state = sel ? if1.dbg_state : if0.dbg_state;

    // Reference: decimal digits of a score by plain arithmetic.
    function automatic logic [11:0] ref_digits(input logic [7:0] v);
        int vi;
        vi = int'(v);
        return {4'(vi / 100), 4'((vi / 10) % 10), 4'(vi % 10)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        score1_v = 8'd0; score2_v = 8'd0; score3_v = 8'd0;
        start_v = 1'b0; stop_v = 1'b0; tick_v = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            checks++; if (o_rank !== 2'd0) begin failures++; $display("FAIL reset_rank dut%0d got=%0d exp=0", s, o_rank); end
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got=%b exp=0", s, o_valid); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", s, o_busy); end
            checks++; if ({o_h, o_t, o_o} !== 12'h000) begin failures++; $display("FAIL reset_digits dut%0d got=%h exp=000", s, {o_h, o_t, o_o}); end
            checks++; if (o_state !== ST_IDLE) begin failures++; $display("FAIL reset_state dut%0d got=%0d exp=%0d", s, o_state, ST_IDLE); end
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one scan on the selected instance and checks every rank against
    // the snapshot model. scenario 0: plain; 1: score change and start
    // pulses mid-scan; 2: continuous, score3 cleared during first rank-2 show.
    task automatic scan(input int period, input int scenario, input int n_ranks, input string name);
        logic [7:0]  snap [3];
        logic [11:0] exp_d;
        logic [1:0]  exp_rank;
        int          low_cnt, counted, shown, phase;
        bit          fin, bad;
        snap[0] = score1_v; snap[1] = score2_v; snap[2] = score3_v;
        start_v = 1'b1;
        @(negedge clk);
        start_v  = 1'b0;
        low_cnt  = 0; counted = 0; shown = 0; phase = 0;
        exp_rank = 2'd1; fin = 1'b0; bad = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            start_v = 1'b0;
            if (phase == 0) begin
                if (!o_valid) begin
                    low_cnt++;
                    if (scenario == 1 && exp_rank == 2'd2 && low_cnt == 4) start_v = 1'b1;
                    if (low_cnt > 9) begin
                        checks++; failures++; bad = 1'b1; fin = 1'b1;
                        $display("FAIL %s rise_gap rank=%0d low_cycles=%0d exp=9", name, exp_rank, low_cnt);
                    end
                end else begin
                    exp_d = ref_digits(snap[exp_rank - 2'd1]);
                    checks++; if (low_cnt !== 9) begin failures++; $display("FAIL %s gap rank=%0d got=%0d exp=9", name, exp_rank, low_cnt); end
                    checks++; if (o_rank !== exp_rank) begin failures++; $display("FAIL %s rank got=%0d exp=%0d", name, o_rank, exp_rank); end
                    checks++; if ({o_h, o_t, o_o} !== exp_d) begin failures++; $display("FAIL %s digits rank=%0d got=%h exp=%h", name, exp_rank, {o_h, o_t, o_o}, exp_d); end
                    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL %s busy_show got=%b exp=1", name, o_busy); end
                    phase = 1; counted = 0;
                    if (scenario == 1 && shown == 0) begin score1_v = 8'd50; start_v = 1'b1; end
                    if (scenario == 2 && shown == 1) score3_v = 8'd0;
                end
            end
            tick_v = ((c % period) == (period - 1));
            if (phase == 1 && !fin) begin
                checks++;
                if (o_valid !== 1'b1 || o_rank !== exp_rank) begin
                    failures++; bad = 1'b1; fin = 1'b1;
                    $display("FAIL %s show_hold rank=%0d valid=%b after_ticks=%0d exp_rank=%0d exp_ticks=%0d", name, o_rank, o_valid, counted, exp_rank, DWELL);
                end else if (tick_v) begin
                    counted++;
                    if (counted == DWELL) begin
                        shown++;
                        if (exp_rank == 2'd3) begin
                            snap[0] = score1_v; snap[1] = score2_v; snap[2] = score3_v;
                            exp_rank = 2'd1;
                        end else begin
                            exp_rank = exp_rank + 2'd1;
                        end
                        phase = 0; low_cnt = 0;
                        if (shown == n_ranks) fin = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        tick_v = 1'b0;
        start_v = 1'b0;
        if (!bad && shown != n_ranks) begin
            checks++; failures++;
            $display("FAIL %s timeout shown=%0d exp=%0d", name, shown, n_ranks);
        end
        if (scenario != 2) begin
            exp_d = ref_digits(snap[2]);
            checks++; if (o_rank !== 2'd0) begin failures++; $display("FAIL %s end_rank got=%0d exp=0", name, o_rank); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL %s end_busy got=%b exp=0", name, o_busy); end
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL %s end_valid got=%b exp=0", name, o_valid); end
            checks++; if ({o_h, o_t, o_o} !== exp_d) begin failures++; $display("FAIL %s end_digits got=%h exp=%h", name, {o_h, o_t, o_o}, exp_d); end
        end else begin
            checks++; if (o_busy !== 1'b1 || o_rank !== 2'd1) begin failures++; $display("FAIL %s wrap_conv busy=%b rank=%0d exp busy=1 rank=1", name, o_busy, o_rank); end
            stop_v = 1'b1;
            @(negedge clk);
            stop_v = 1'b0;
            checks++; if ({o_rank, o_valid, o_busy} !== 4'b0000) begin failures++; $display("FAIL %s wrap_stop rank=%0d valid=%b busy=%b exp=0/0/0", name, o_rank, o_valid, o_busy); end
        end
        @(negedge clk);
    endtask

    task automatic test_basic_scan();
        sel = 1'b0;
        score1_v = 8'd255; score2_v = 8'd100; score3_v = 8'd7;
        scan(5, 0, 3, "basic");
    endtask

    task automatic test_snapshot_isolation();
        sel = 1'b0;
        score1_v = 8'd255; score2_v = 8'd100; score3_v = 8'd7;
        scan(3, 1, 3, "snapshot");
        score1_v = 8'd255;
    endtask

    task automatic test_random_scores();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            score1_v = 8'($urandom_range(0, 255));
            score2_v = 8'($urandom_range(0, 255));
            score3_v = 8'($urandom_range(0, 255));
            scan(int'($urandom_range(1, 6)), 0, 3, "random");
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        sel = 1'b0;
        score1_v = 8'd255; score2_v = 8'd100; score3_v = 8'd7;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        tick_v = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (o_rank == 2'd2) seen = 1'b1;
            else @(negedge clk);
        end
        tick_v = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL reset_mid rank2_timeout got_rank=%0d exp=2", o_rank); end
        repeat (3) @(negedge clk);
        checks++; if ({o_rank, o_valid, o_busy} !== 4'b1001) begin failures++; $display("FAIL reset_mid pre rank=%0d valid=%b busy=%b exp=2/0/1", o_rank, o_valid, o_busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({o_rank, o_valid, o_busy} !== 4'b0000) begin failures++; $display("FAIL reset_mid ctrl rank=%0d valid=%b busy=%b exp=0/0/0", o_rank, o_valid, o_busy); end
        checks++; if ({o_h, o_t, o_o} !== 12'h000) begin failures++; $display("FAIL reset_mid digits got=%h exp=000", {o_h, o_t, o_o}); end
        checks++; if (o_state !== ST_IDLE) begin failures++; $display("FAIL reset_mid state got=%0d exp=%0d", o_state, ST_IDLE); end
        @(negedge clk);
    endtask

    task automatic test_stop();
        bit seen;
        sel = 1'b0;
        score1_v = 8'd42; score2_v = 8'd17; score3_v = 8'd3;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (o_valid) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen || {o_h, o_t, o_o} !== ref_digits(8'd42)) begin failures++; $display("FAIL stop_pre_show seen=%b digits=%h exp=%h", seen, {o_h, o_t, o_o}, ref_digits(8'd42)); end
        stop_v = 1'b1; tick_v = 1'b1;
        @(negedge clk);
        stop_v = 1'b0; tick_v = 1'b0;
        checks++; if ({o_rank, o_valid, o_busy} !== 4'b0000) begin failures++; $display("FAIL stop_show rank=%0d valid=%b busy=%b exp=0/0/0", o_rank, o_valid, o_busy); end
        start_v = 1'b1; stop_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0; stop_v = 1'b0;
        checks++; if ({o_rank, o_busy} !== 3'b000) begin failures++; $display("FAIL stop_start_idle rank=%0d busy=%b exp=0/0", o_rank, o_busy); end
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({o_rank, o_busy} !== 3'b011) begin failures++; $display("FAIL stop_conv_pre rank=%0d busy=%b exp=1/1", o_rank, o_busy); end
        stop_v = 1'b1;
        @(negedge clk);
        stop_v = 1'b0;
        checks++; if ({o_rank, o_valid, o_busy} !== 4'b0000) begin failures++; $display("FAIL stop_conv rank=%0d valid=%b busy=%b exp=0/0/0", o_rank, o_valid, o_busy); end
        @(negedge clk);
    endtask

    task automatic test_continuous();
        sel = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        score1_v = 8'd9; score2_v = 8'd99; score3_v = 8'd199;
        scan(1, 2, 6, "continuous");
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic_scan();
        test_snapshot_isolation();
        test_random_scores();
        test_reset_mid();
        test_stop();
        test_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leaderboard_scanner.md
# leaderboard_scanner

Read-side companion to the top-three leaderboard registers. It snapshots the three stored scores, converts each 8-bit binary score to three BCD digits with a sequential shift-add-3 converter, and presents them rank by rank for a fixed dwell time. The outputs drive the seven-segment or VGA score overlay. It sits between the leaderboard outputs (score1..score3) and the display driver, paced by a slow tick from the display prescaler.

## Interface
- DWELL, 4: number of `tick` pulses each rank is held on the outputs; legal range 1..255.
- CONTINUOUS, 0: 0 means stop after rank 3; 1 means wrap to rank 1 with a fresh snapshot.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- score1  in  8  leaderboard first place, binary 0..255.
- score2  in  8  leaderboard second place.
- score3  in  8  leaderboard third place.
- start  in  1  level-sampled; starts a scan when the block is idle.
- stop  in  1  synchronous abort of an in-progress scan.
- tick  in  1  one-cycle dwell strobe from the prescaler.
- rank  out  2  rank currently being converted or shown: 1..3; 0 when idle.
- bcd_h  out  4  hundreds digit of the shown score.
- bcd_t  out  4  tens digit of the shown score.
- bcd_o  out  4  ones digit of the shown score.
- valid  out  1  digits are stable and belong to `rank`.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset, dominant over every other input:
  - State goes to IDLE.
  - rank=0, bcd_h/t/o=0, valid=0, busy=0.
  - Snapshot registers, dwell counter and iteration counter clear to 0.
- FSM states: IDLE, CONV, SHOW.
- IDLE with start=1:
  - Copy score1..3 into the snapshot registers.
  - rank←1, load the converter with snap1, go to CONV, busy←1.
- CONV:
  - Performs 8 shift-add-3 iterations, one per clock; the iteration counter runs 0..7.
  - During each iteration, any BCD nibble ≥5 gets +3 before the shift.
  - After the 8th iteration, latch the digits into bcd_h/t/o, set valid←1, clear the dwell counter, go to SHOW.
  - tick is ignored in CONV.
- SHOW:
  - Each cycle with tick=1 increments the dwell counter.
  - On the edge where the counter reaches DWELL: valid←0.
  - If rank<3: rank+1, load the converter with the next snapshot, go to CONV.
  - If rank=3 and CONTINUOUS=0: go to IDLE, rank←0, busy←0. bcd_h/t/o hold their last value.
  - If rank=3 and CONTINUOUS=1: take a fresh snapshot, rank←1, go to CONV.
- stop=1 in CONV or SHOW: next state IDLE, rank←0, valid←0, busy←0. stop has priority over tick and start.
- start while busy is ignored. start and stop together while IDLE: stop wins and the block stays IDLE.
- Leaderboard updates during a scan do not affect the digits shown; only the snapshot is used.
- Width rules:
  - Converter working register is 20 bits: 12 BCD bits plus 8 binary bits.
  - The maximum result, 255, is 2/5/5, so bcd_h is never greater than 2.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- Edges E1..E8 perform the iterations. valid goes high after E9.
- Start-to-first-valid latency is 9 clocks.
- Rank-to-rank gap: valid is low for exactly 9 clocks between ranks (the advance edge plus 8 iterations, then the latch edge).
- A tick on the same edge that advances rank is consumed by that advance. It is not counted toward the next rank.
- Outputs are registered and there is no combinational path from input to output.
- Reset asserted mid-CONV: the state is IDLE at the next edge and there is no partial digit output.

## Structure
- The shared game package defines:
  - Score width 8 and BCD width 4.
  - The rank encoding: 0 = none, 1..3 = places.
  - The FSM state enum.
- One sub-module, `bin2bcd_seq`:
  - Ports: load, bin[7:0], done, bcd_h/t/o.
  - Implements the 8-iteration double-dabble with its own 3-bit counter.
- The top level holds the snapshot registers, the FSM and the dwell counter.

## Test plan
- Basic scan. Scores 255/100/7, DWELL=4, one start pulse, tick every 5 clocks. Required:
  - valid rises 9 clocks after start.
  - rank 1 shows 2/5/5, rank 2 shows 1/0/0, rank 3 shows 0/0/7.
  - Then IDLE with rank=0 and busy=0.
- Snapshot isolation and start while busy. Change score1 to 50 during the rank 1 SHOW and pulse start mid-scan. Required:
  - All three ranks still show 255/100/7.
  - The start pulse causes no restart.
- Reset mid-operation. Assert reset on the 4th CONV cycle of rank 2. Required: next edge gives rank=0, valid=0, busy=0, digits 0/0/0.
- Continuous wrap. CONTINUOUS=1 with scores 9/99/199. Change score3 to 0 during the rank 2 SHOW. Required:
  - The first pass shows 0/0/9, 0/9/9, 1/9/9.
  - Rank 1 reappears with a 9-clock gap.
  - The second pass shows 0/0/0 for rank 3.
- Stop and edge ticks:
  - stop during SHOW with tick=1 on the same cycle → IDLE next edge.
  - A tick on the same edge that advances rank is not counted toward the next rank.
  - A tick during CONV is not counted.
